// File: rtl/seq_calc_unit.sv
// Sequential unsigned calculator: add/sub complete in one cycle.
// Multiply (shift-add) and divide (restoring) are iterative, one bit per
// cycle. The START/DONE handshake accepts a new request in IDLE or FIN.
//
// state | meaning
// IDLE  | waiting for START, outputs hold the last result
// CALC  | operation in progress (BUSY=1)
// FIN   | outputs just updated, DONE=1 for this cycle only
module seq_calc_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             OVF,
    output logic             DIV0
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 ovf_q, ovf_d;
    logic                 div0_q, div0_d;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_next;

    // Datapath steps: single-cycle add/sub and one mul/div iteration.
    // Mul accumulator is {partial high, remaining multiplier bits}; div
    // accumulator is {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        add_sum   = {1'b0, a_q} + {1'b0, b_q};
        sub_diff  = {1'b0, a_q} - {1'b0, b_q};
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
        // Partial remainder stays below B, so neither branch loses a bit.
        if (!div_trial[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        div0_d  = div0_q;

        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    op_d    = OP;
                    a_d     = IN_A;
                    b_d     = IN_B;
                    cnt_d   = '0;
                    acc_d   = (OP == OP_DIV) ? {{WIDTH{1'b0}}, IN_A} : {{WIDTH{1'b0}}, IN_B};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                case (op_q)
                    OP_ADD: begin
                        res_d   = add_sum[WIDTH-1:0];
                        hi_d    = '0;
                        ovf_d   = add_sum[WIDTH];
                        div0_d  = 1'b0;
                        state_d = FIN;
                    end
                    OP_SUB: begin
                        res_d   = sub_diff[WIDTH-1:0];
                        hi_d    = '0;
                        ovf_d   = sub_diff[WIDTH];
                        div0_d  = 1'b0;
                        state_d = FIN;
                    end
                    OP_MUL: begin
                        acc_d = mul_next;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            res_d   = mul_next[WIDTH-1:0];
                            hi_d    = mul_next[2*WIDTH-1:WIDTH];
                            ovf_d   = |mul_next[2*WIDTH-1:WIDTH];
                            div0_d  = 1'b0;
                            state_d = FIN;
                        end
                    end
                    default: begin
                        if (b_q == '0) begin
                            res_d   = '1;
                            hi_d    = a_q;
                            ovf_d   = 1'b0;
                            div0_d  = 1'b1;
                            state_d = FIN;
                        end else begin
                            acc_d = div_next;
                            cnt_d = cnt_q + CW'(1);
                            if (cnt_q == LAST) begin
                                res_d   = div_next[WIDTH-1:0];
                                hi_d    = div_next[2*WIDTH-1:WIDTH];
                                ovf_d   = 1'b0;
                                div0_d  = 1'b0;
                                state_d = FIN;
                            end
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
        end
    end

    assign BUSY      = (state_q == CALC);
    assign DONE      = (state_q == FIN);
    assign RESULT    = res_q;
    assign RESULT_HI = hi_q;
    assign OVF       = ovf_q;
    assign DIV0      = div0_q;

endmodule
